// File: rtl/tone_frame_packer.sv
`timescale 1ns/1ps
// tone_frame_packer
//
// Packs tone samples from the frequency selector into framed packets for the
// DMA. Samples arrive without backpressure, are buffered in a first-word-
// fall-through FIFO and leave as: header word, payload words, trailer word.
// When the FIFO is short of room, samples are dropped and the loss is
// recorded in sticky statistics.
//
// Ports
//   dev_clk, dev_rstn     clock, asynchronous active-low reset
//   enable                frame capture enable, looked at only at frame start
//   clear_stat            one-cycle pulse clearing overflow/drop_count/frames_lost
//   s_axis_*              sample input: tdata[79:0], tuser {index[6:0], k[13:0]},
//                         tlast, tvalid; tready is constantly 1
//   m_axis_*              packet output: tdata[79:0], tuser {kind[1:0], index[6:0]},
//                         tlast on the trailer only, tvalid/tready handshake
//   overflow              sticky flag, at least one sample dropped
//   drop_count            dropped samples, saturating
//   frames_lost           frames whose samples were all dropped, saturating
module tone_frame_packer #(
  parameter int          FIFO_DEPTH = 64,
  parameter logic [15:0] MAGIC      = 16'hF5E1
) (
  input  logic        dev_clk,
  input  logic        dev_rstn,
  input  logic        enable,
  input  logic        clear_stat,
  input  logic [79:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [20:0] s_axis_tuser,
  input  logic        s_axis_tlast,
  output logic [79:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [8:0]  m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        overflow,
  output logic [15:0] drop_count,
  output logic [15:0] frames_lost
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam int          EW       = 80 + 21 + 2;
  localparam logic [AW:0] LIM_LAST = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] LIM_BODY = (AW+1)'(FIFO_DEPTH - 1);

  typedef enum logic {IN_IDLE, IN_CAPT} in_state_t;
  typedef enum logic [1:0] {OUT_HDR = 2'd0, OUT_PAY = 2'd1, OUT_TRL = 2'd2} out_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // FIFO storage and pointers
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // Input side state
  in_state_t r_in_state;
  logic      r_skip;       // frame started while disabled, discard until tlast
  logic      r_drop_flag;  // a sample of the current frame has been dropped
  logic      r_stored;     // a sample of the current frame has been stored

  // Output side state
  out_state_t  r_out_state;
  logic [31:0] r_seq;
  logic [15:0] r_pay_cnt;
  logic        r_err;

  // Statistics
  logic        r_overflow;
  logic [15:0] r_drop_count;
  logic [15:0] r_frames_lost;

  logic          w_in_frame;
  logic          w_fits;
  logic          w_push;
  logic          w_drop;
  logic          w_lost;
  logic [EW-1:0] w_wr_entry;
  logic [EW-1:0] w_head;
  logic [79:0]   w_head_data;
  logic [20:0]   w_head_user;
  logic          w_head_last;
  logic          w_head_err;
  logic          w_empty;
  logic          w_tvalid;
  logic          w_hs;
  logic          w_pop;
  logic [79:0]   w_tdata;
  logic [8:0]    w_tuser;
  logic          w_tlast;

  // A sample belongs to a captured frame when already capturing, or when it
  // opens a frame with enable high and no discarded frame is in progress.
  assign w_in_frame = s_axis_tvalid &&
                      ((r_in_state == IN_CAPT) || (!r_skip && enable));
  // Non-last samples leave one slot free so the frame's last sample always
  // has a chance to close the frame in the FIFO.
  assign w_fits     = s_axis_tlast ? (r_count < LIM_LAST) : (r_count < LIM_BODY);
  assign w_push     = w_in_frame && w_fits;
  assign w_drop     = w_in_frame && !w_fits;
  assign w_lost     = w_drop && s_axis_tlast && !r_stored;
  assign w_wr_entry = {s_axis_tdata, s_axis_tuser, s_axis_tlast, r_drop_flag};

  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_data = w_head[EW-1:23];
  assign w_head_user = w_head[22:2];
  assign w_head_last = w_head[1];
  assign w_head_err  = w_head[0];
  assign w_empty     = (r_count == '0);

  assign w_tvalid = (r_out_state == OUT_TRL) || !w_empty;
  assign w_hs     = w_tvalid && m_axis_tready;
  assign w_pop    = w_hs && (r_out_state == OUT_PAY);

  always_ff @(posedge dev_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wr_entry;
  end

  always_ff @(posedge dev_clk or negedge dev_rstn) begin
    if (!dev_rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Input FSM
  always_ff @(posedge dev_clk or negedge dev_rstn) begin
    if (!dev_rstn) begin
      r_in_state  <= IN_IDLE;
      r_skip      <= 1'b0;
      r_drop_flag <= 1'b0;
      r_stored    <= 1'b0;
    end else if (s_axis_tvalid) begin
      case (r_in_state)
        IN_IDLE: begin
          if (r_skip) begin
            if (s_axis_tlast) r_skip <= 1'b0;
          end else if (!enable) begin
            r_skip <= !s_axis_tlast;
          end else if (!s_axis_tlast) begin
            r_in_state <= IN_CAPT;
          end
        end
        default: begin
          if (s_axis_tlast) r_in_state <= IN_IDLE;
        end
      endcase
      if (w_in_frame) begin
        r_drop_flag <= s_axis_tlast ? 1'b0 : (r_drop_flag | w_drop);
        r_stored    <= s_axis_tlast ? 1'b0 : (r_stored | w_push);
      end
    end
  end

  // Output FSM
  always_ff @(posedge dev_clk or negedge dev_rstn) begin
    if (!dev_rstn) begin
      r_out_state <= OUT_HDR;
      r_seq       <= '0;
      r_pay_cnt   <= '0;
      r_err       <= 1'b0;
    end else if (w_hs) begin
      case (r_out_state)
        OUT_HDR: r_out_state <= OUT_PAY;
        OUT_PAY: begin
          r_pay_cnt <= sat_inc16(r_pay_cnt);
          r_err     <= w_head_err;
          if (w_head_last) r_out_state <= OUT_TRL;
        end
        default: begin
          r_seq       <= r_seq + 32'd1;
          r_pay_cnt   <= '0;
          r_out_state <= OUT_HDR;
        end
      endcase
    end
  end

  // Output word; everything reads zero while no word is offered
  always_comb begin
    w_tdata = '0;
    w_tuser = '0;
    w_tlast = 1'b0;
    if (w_tvalid) begin
      case (r_out_state)
        OUT_HDR: begin
          w_tdata = {MAGIC, r_seq, w_head_user[13:0], 18'd0};
          w_tuser = {2'b01, 7'd0};
        end
        OUT_PAY: begin
          w_tdata = w_head_data;
          w_tuser = {2'b10, w_head_user[20:14]};
        end
        default: begin
          w_tdata = {~MAGIC, r_seq, r_err, 15'd0, r_pay_cnt};
          w_tuser = {2'b11, 7'd0};
          w_tlast = 1'b1;
        end
      endcase
    end
  end

  // Statistics; a drop coinciding with clear_stat is kept
  always_ff @(posedge dev_clk or negedge dev_rstn) begin
    if (!dev_rstn) begin
      r_overflow    <= 1'b0;
      r_drop_count  <= '0;
      r_frames_lost <= '0;
    end else if (clear_stat) begin
      r_overflow    <= w_drop;
      r_drop_count  <= {15'd0, w_drop};
      r_frames_lost <= {15'd0, w_lost};
    end else if (w_drop) begin
      r_overflow   <= 1'b1;
      r_drop_count <= sat_inc16(r_drop_count);
      if (w_lost) r_frames_lost <= sat_inc16(r_frames_lost);
    end
  end

  assign s_axis_tready = 1'b1;
  assign m_axis_tdata  = w_tdata;
  assign m_axis_tvalid = w_tvalid;
  assign m_axis_tuser  = w_tuser;
  assign m_axis_tlast  = w_tlast;
  assign overflow      = r_overflow;
  assign drop_count    = r_drop_count;
  assign frames_lost   = r_frames_lost;

endmodule
